mem_init_engine: RTL and testbench

Parametrised memory initialiser for the RC4 datapath. It sequentially writes every location of a single-port synchronous RAM with a mode-selected pattern: identity, constant fill, arithmetic progression or reverse identity. A start/busy/done handshake controls each pass, and writes wait on a grant from the memory arbiter, so the block can share the RAM port with the key-scheduling and decrypt loops. An optional read-back pass checks the fill.

---
 rtl/mem_init_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_init_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_init_engine.sv
// mem_init_engine
//   Sequentially writes every RAM location 0 .. DEPTH-1 with a mode-selected
//   pattern. The RAM port is shared through an arbiter: an access completes
//   only on an edge where grant=1, otherwise the block holds every output.
//
//   Patterns (mod 2^DATA_W, address zero-extended or truncated to DATA_W):
//     mode 0 : index
//     mode 1 : base
//     mode 2 : base + index*step, built with a running accumulator
//     mode 3 : DEPTH-1-index
//
//   Optional read-back check, enabled by defining MEM_INIT_VERIFY_EN:
//   after the fill the block sweeps the RAM again with rden and compares
//   q (one-cycle read latency) against the expected pattern. Without the
//   macro, rden/verify_err/err_addr are tied to 0 and q is ignored.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start, start_over   begin a pass (IDLE/DONE only) / synchronous abort
//   mode, base, step    pattern controls, latched when start is accepted
//   grant               arbiter grant for the current access
//   q                   RAM read data (verify only)
//   address, data       RAM address / write data
//   wren, rden          write / read request
//   busy, done_flag     pass in progress / pass finished
//   verify_err,err_addr sticky mismatch flag / first mismatching address
module mem_init_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_over,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] step,
  input  logic              grant,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              rden,
  output logic              busy,
  output logic              done_flag,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;   // base + idx*step for mode 2
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] pattern;

`ifdef MEM_INIT_VERIFY_EN
  logic              verify_err_q, verify_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  // One-stage compare pipeline: the expected value and address of a granted
  // read wait here for the RAM data that arrives a cycle later.
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;

  assign verify_err = verify_err_q;
  assign err_addr   = err_addr_q;
`else
  logic unused_q;
  assign unused_q   = ^q;
  assign verify_err = 1'b0;
  assign err_addr   = '0;
`endif

  always_comb begin
    case (mode_q)
      2'd0:    pattern = DATA_W'(idx_q);
      2'd1:    pattern = base_q;
      2'd2:    pattern = acc_q;
      default: pattern = DATA_W'(LAST_IDX - idx_q);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    base_d    = base_q;
    step_d    = step_q;
    address   = '0;
    data      = '0;
    wren      = 1'b0;
    rden      = 1'b0;
    busy      = 1'b0;
    done_flag = 1'b0;
`ifdef MEM_INIT_VERIFY_EN
    verify_err_d = verify_err_q;
    err_addr_d   = err_addr_q;
    cmp_vld_d    = 1'b0;
    cmp_exp_d    = cmp_exp_q;
    cmp_addr_d   = cmp_addr_q;
    // Only the first mismatch records its address.
    if (cmp_vld_q && (q != cmp_exp_q) && !verify_err_q) begin
      verify_err_d = 1'b1;
      err_addr_d   = cmp_addr_q;
    end
`endif

    case (state_q)
      S_FILL: begin
        busy    = 1'b1;
        wren    = 1'b1;
        address = idx_q;
        data    = pattern;
        if (grant) begin
          acc_d = acc_q + step_q;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            acc_d = base_q;  // rewind so the read-back sweep regenerates the pattern
`ifdef MEM_INIT_VERIFY_EN
            state_d = S_VERIFY;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
`ifdef MEM_INIT_VERIFY_EN
      S_VERIFY: begin
        busy    = 1'b1;
        rden    = 1'b1;
        address = idx_q;
        if (grant) begin
          cmp_vld_d  = 1'b1;
          cmp_exp_d  = pattern;
          cmp_addr_d = idx_q;
          acc_d      = acc_q + step_q;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Waits for the data of the last read; no RAM access, grant ignored.
        busy    = 1'b1;
        state_d = S_DONE;
      end
`endif
      default: begin  // S_IDLE, S_DONE
        done_flag = (state_q == S_DONE);
        if (start) begin
          state_d = S_FILL;
          idx_d   = '0;
          acc_d   = base;
          mode_d  = mode;
          base_d  = base;
          step_d  = step;
`ifdef MEM_INIT_VERIFY_EN
          verify_err_d = 1'b0;
          err_addr_d   = '0;
`endif
        end
      end
    endcase

    // Abort wins over everything, including a start on the same edge.
    if (start_over) begin
      state_d = S_IDLE;
      idx_d   = '0;
`ifdef MEM_INIT_VERIFY_EN
      verify_err_d = 1'b0;
      err_addr_d   = '0;
      cmp_vld_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      mode_q  <= '0;
      base_q  <= '0;
      step_q  <= '0;
`ifdef MEM_INIT_VERIFY_EN
      verify_err_q <= 1'b0;
      err_addr_q   <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_exp_q    <= '0;
      cmp_addr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      step_q  <= step_d;
`ifdef MEM_INIT_VERIFY_EN
      verify_err_q <= verify_err_d;
      err_addr_q   <= err_addr_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_addr_q   <= cmp_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_init_engine.sv
// Directed bench for mem_init_engine (ADDR_W=8, DATA_W=8, DEPTH=256).
// Expected writes are queued when a pass is started and popped as the DUT
// completes each granted write. A behavioural RAM holds the written data
// and supplies q; it can corrupt address 7 for the read-back check.
module tb_mem_init_engine;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int D  = 256;
`ifdef MEM_INIT_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          start_over = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] base = '0;
  logic [DW-1:0] step_in = '0;
  logic          grant = 1'b0;
  logic [DW-1:0] q;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          wren, rden, busy, done_flag, verify_err;
  logic [AW-1:0] err_addr;

  mem_init_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_over(start_over),
    .mode(mode), .base(base), .step(step_in), .grant(grant), .q(q),
    .address(address), .data(data), .wren(wren), .rden(rden), .busy(busy),
    .done_flag(done_flag), .verify_err(verify_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_exp = 0;
  bit gtoggle = 1'b0;
  bit corrupt = 1'b0;
  logic [DW-1:0] mem [0:D-1];

  // RAM model: granted writes land, read data appears one cycle later.
  always @(posedge clk) begin
    if (wren === 1'b1 && grant === 1'b1)
      mem[address] <= (corrupt && address == 8'd7) ? ~data : data;
    q <= mem[address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    wr_t e;
    if (wren === 1'b1) begin
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        if (grant === 1'b1) begin
          e = sb.pop_front();
          chk("wr_addr", 32'(address), 32'(e.a));
          chk("wr_data", 32'(data), 32'(e.d));
        end else begin
          chk("wr_hold_addr", 32'(address), 32'(sb[0].a));
        end
      end
    end
    if (rden === 1'b1 && grant === 1'b1) begin
      chk("rd_addr", 32'(address), 32'(rd_exp));
      rd_exp++;
    end
  endtask

  // Advance one cycle; the grant for the edge ending this cycle is driven here.
  task automatic tick();
    @(negedge clk);
    cyc++;
    grant = gtoggle ? (cyc % 2 == 0) : 1'b1;
    mon();
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] b,
                                          input logic [DW-1:0] s, input int k);
    case (m)
      2'd0:    return DW'(k);
      2'd1:    return b;
      2'd2:    return DW'(int'(b) + k * int'(s));
      default: return DW'(D - 1 - k);
    endcase
  endfunction

  task automatic launch(input logic [1:0] m, input logic [DW-1:0] b, input logic [DW-1:0] s,
                        input bit tog);
    sb.delete();
    rd_exp = 0;
    @(negedge clk);
    cyc = 0;
    gtoggle = tog;
    grant = 1'b1;
    for (int k = 0; k < D; k++) sb.push_back('{a: AW'(k), d: model(m, b, s, k)});
    mode = m; base = b; step_in = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_pass(input logic [1:0] m, input logic [DW-1:0] b, input logic [DW-1:0] s,
                          input bit tog, input int mid_start);
    int got_done;
    int exp_done;
    launch(m, b, s, tog);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_wren", 32'(wren), 32'd1);
    chk("c1_addr", 32'(address), 32'd0);
    chk("c1_done", 32'(done_flag), 32'd0);
    got_done = -1;
    while (cyc < 5 * D) begin
      if (done_flag === 1'b1) begin
        got_done = cyc;
        break;
      end
      if (cyc == mid_start) begin
        start = 1'b1; mode = ~m; base = ~b;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    exp_done = (VER ? 2 * D + 2 : D + 1) + (tog ? D * (VER ? 2 : 1) : 0);
    chk("done_cycle", 32'(got_done), 32'(exp_done));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_wren", 32'(wren), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    if (VER) chk("rd_count", 32'(rd_exp), 32'(D));
    else     chk("no_rden", 32'(rden), 32'd0);
    $display("pass mode=%0d base=%02h step=%02h toggle=%0d done_cycle=%0d", m, b, s, tog, got_done);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(address), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_wren"}, 32'(wren), 32'd0);
    chk({tag, "_rden"}, 32'(rden), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done_flag), 32'd0);
    chk({tag, "_verr"}, 32'(verify_err), 32'd0);
    chk({tag, "_eaddr"}, 32'(err_addr), 32'd0);
  endtask

  task automatic mem_check(input string tag, input logic [1:0] m, input logic [DW-1:0] b,
                           input logic [DW-1:0] s);
    int bad = 0;
    for (int k = 0; k < D; k++) if (mem[k] !== model(m, b, s, k)) bad++;
    chk(tag, 32'(bad), 32'd0);
    $display("ram contents %s: %0d bad locations", tag, bad);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    $display("reset released");

    // Identity fill, grant held high
    run_pass(2'd0, 8'h00, 8'h00, 1'b0, -1);
    mem_check("ram_mode0", 2'd0, 8'h00, 8'h00);

    // Progression with wrap; a start during FILL (with other mode/base) is ignored
    run_pass(2'd2, 8'h10, 8'h03, 1'b0, 50);
    chk("m2_addr0", 32'(mem[0]), 32'h10);
    chk("m2_addr1", 32'(mem[1]), 32'h13);
    chk("m2_addr2", 32'(mem[2]), 32'h16);
    chk("m2_addr100", 32'(mem[100]), 32'h3C);

    // Constant fill
    run_pass(2'd1, 8'hA5, 8'h00, 1'b0, -1);
    mem_check("ram_mode1", 2'd1, 8'hA5, 8'h00);

    // Reverse identity with grant toggling 0,1,0,1...
    run_pass(2'd3, 8'h00, 8'h00, 1'b1, -1);
    mem_check("ram_mode3", 2'd3, 8'h00, 8'h00);

    // Abort at address 40
    launch(2'd0, 8'h00, 8'h00, 1'b0);
    while (address !== 8'd40 && cyc < 100) tick();
    chk("so_at_addr", 32'(address), 32'd40);
    start_over = 1'b1;
    tick();
    start_over = 1'b0;
    chk("so_wren", 32'(wren), 32'd0);
    chk("so_busy", 32'(busy), 32'd0);
    chk("so_done", 32'(done_flag), 32'd0);
    chk("so_addr", 32'(address), 32'd0);
    sb.delete();
    repeat (3) tick();
    chk("so_idle_done", 32'(done_flag), 32'd0);
    chk("so_idle_wren", 32'(wren), 32'd0);
    $display("start_over at address 40 handled");
    run_pass(2'd0, 8'h00, 8'h00, 1'b0, -1);

    // Asynchronous reset mid-FILL
    launch(2'd1, 8'h3C, 8'h00, 1'b0);
    repeat (20) tick();
    #1 reset_n = 1'b0;
    #1 chk_all_zero("rst_fill");
    tick();
    reset_n = 1'b1;
    sb.delete();
    $display("reset mid-fill applied");
    run_pass(2'd2, 8'h01, 8'h07, 1'b0, -1);
    mem_check("ram_after_rst", 2'd2, 8'h01, 8'h07);

`ifdef MEM_INIT_VERIFY_EN
    // Read-back with a RAM that corrupts address 7
    corrupt = 1'b1;
    run_pass(2'd0, 8'h00, 8'h00, 1'b0, -1);
    chk("ver_err", 32'(verify_err), 32'd1);
    chk("ver_err_addr", 32'(err_addr), 32'd7);
    corrupt = 1'b0;
    // Clean RAM
    run_pass(2'd2, 8'h5A, 8'h11, 1'b0, -1);
    chk("ver_clean", 32'(verify_err), 32'd0);
    chk("ver_clean_addr", 32'(err_addr), 32'd0);
    // Clean RAM with grant toggling through fill and verify
    run_pass(2'd3, 8'h00, 8'h00, 1'b1, -1);
    chk("ver_tog_clean", 32'(verify_err), 32'd0);
    // Asynchronous reset mid-VERIFY
    launch(2'd0, 8'h00, 8'h00, 1'b0);
    repeat (D + 50) tick();
    chk("mid_ver_rden", 32'(rden), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("rst_ver");
    tick();
    reset_n = 1'b1;
    sb.delete();
    $display("reset mid-verify applied");
    run_pass(2'd0, 8'h00, 8'h00, 1'b0, -1);
    chk("ver_after_rst", 32'(verify_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
